md_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit owning the HI/LO registers.
- Sits beside the ALU in the execute stage of the 5-stage pipeline.
- Generalises the single-cycle ALU path with configurable operand width and per-operation latencies.
- Adds a busy handshake that the decode-stage hazard logic uses to stall instructions reading or writing HI/LO.

---
 rtl/md_unit.sv | 188 ++++++++++++++++++
 tb/tb_md_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Results are computed at acceptance and held in pending registers until the latency expires.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             is_signed);
    logic [2*WIDTH-1:0] ea;
    logic [2*WIDTH-1:0] eb;
    ea = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    eb = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] a);
    return ~a + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Returns {remainder, quotient}; signed mode divides magnitudes then fixes signs
  function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             is_signed);
    logic [WIDTH-1:0] ua;
    logic [WIDTH-1:0] ub;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    ua = (is_signed && a[WIDTH-1]) ? negate(a) : a;
    ub = (is_signed && b[WIDTH-1]) ? negate(b) : b;
    if (ub == {WIDTH{1'b0}}) begin
      q = {WIDTH{1'b0}};
      r = {WIDTH{1'b0}};
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (is_signed && (a[WIDTH-1] ^ b[WIDTH-1])) begin
      q = negate(q);
    end else begin
      q = q;
    end
    if (is_signed && a[WIDTH-1]) begin
      r = negate(r);
    end else begin
      r = r;
    end
    return {r, q};
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;

  logic [2*WIDTH-1:0] mul_res;
  logic [2*WIDTH-1:0] div_res;

  // Arithmetic datapath evaluated on the live operands; only captured at acceptance
  always_comb begin
    mul_res = mul_full(in0, in1, op == OP_MULT);
    div_res = div_full(in0, in1, op == OP_DIV);
  end

  // Next-state logic for the IDLE/RUN sequencer and HI/LO registers
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = mul_res[2*WIDTH-1:WIDTH];
              pend_lo_d = mul_res[WIDTH-1:0];
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = div_res[2*WIDTH-1:WIDTH];
              pend_lo_d = div_res[WIDTH-1:0];
              // A zero divisor still occupies the unit but leaves HI/LO untouched
              pend_wr_d = (in1 != {WIDTH{1'b0}});
              cnt_d     = DIV_LOAD;
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = in0;
            OP_MTLO: lo_d = in0;
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == {CW{1'b0}}) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
          end
          pend_wr_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      pend_hi_q <= {WIDTH{1'b0}};
      pend_lo_q <= {WIDTH{1'b0}};
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: a 32-bit default instance and an 8-bit single-cycle-multiply instance.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start32;
  logic        start8;
  logic [2:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        busy32;
  logic [31:0] hi32;
  logic [31:0] lo32;
  logic        busy8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .in0(in0), .in1(in1),
    .busy(busy32), .hi(hi32), .lo(lo32)
  );

  md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .in0(in0[7:0]), .in1(in1[7:0]),
    .busy(busy8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    bit          sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks;
  int          failures;
  logic [31:0] hm[2];
  logic [31:0] lm[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  // Monitor: one expected snapshot per clock, sampled 1ns after the edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) begin
        check({e.name, ".busy8"}, {31'd0, busy8}, {31'd0, e.busy});
        check({e.name, ".hi8"}, {24'd0, hi8}, e.hi);
        check({e.name, ".lo8"}, {24'd0, lo8}, e.lo);
      end else begin
        check({e.name, ".busy"}, {31'd0, busy32}, {31'd0, e.busy});
        check({e.name, ".hi"}, hi32, e.hi);
        check({e.name, ".lo"}, lo32, e.lo);
      end
    end
  end

  task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int n, input logic [31:0] eh,
                       input logic [31:0] el, input string nm);
    op  = o;
    in0 = a;
    in1 = b;
    if (sel) start8 = 1'b1;
    else     start32 = 1'b1;
    for (int i = 0; i < n; i++) sb.push_back('{sel, 1'b1, hm[sel], lm[sel], nm});
    sb.push_back('{sel, 1'b0, eh, el, nm});
    hm[sel] = eh;
    lm[sel] = el;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input string nm);
    issue(sel, o, a, b, n, eh, el, nm);
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
    in0     = 32'h5A5A_A5A5;
    in1     = 32'h0F0F_F0F0;
    wait_drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start32  = 1'b0;
    start8   = 1'b0;
    op       = 3'd7;
    in0      = 32'd0;
    in1      = 32'd0;
    hm[0] = 32'd0; lm[0] = 32'd0; hm[1] = 32'd0; lm[1] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    sb.push_back('{1'b0, 1'b0, 32'd0, 32'd0, "reset"});
    @(negedge clk);
    reset = 1'b0;
    wait_drain();

    run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult_neg");
    run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
    run_op(1'b0, 3'd3, 32'h0000_0007, 32'h0000_0000, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_by0");
    run_op(1'b0, 3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
    run_op(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_op(1'b0, 3'd4, 32'h1234_5678, 32'h0000_0000, 0, 32'h1234_5678, 32'h8000_0000, "mthi");
    run_op(1'b0, 3'd5, 32'h0000_DEAD, 32'h0000_0000, 0, 32'h1234_5678, 32'h0000_DEAD, "mtlo");
    run_op(1'b0, 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h1234_5678, 32'h0000_DEAD, "noop");

    // MULTU 3*4 with an MTLO attempted while busy; it must be dropped
    issue(1'b0, 3'd1, 32'd3, 32'd4, 5, 32'h0000_0000, 32'h0000_000C, "multu_ign");
    @(negedge clk);
    start32 = 1'b0;
    in0     = 32'd9;
    in1     = 32'd9;
    @(negedge clk);
    op      = 3'd5;
    in0     = 32'h0000_DEAD;
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_drain();

    run_op(1'b0, 3'd4, 32'hCAFE_F00D, 32'h0000_0000, 0, 32'hCAFE_F00D, 32'h0000_000C, "mthi2");

    // DIVU aborted by reset sampled at edge T+3; no commit may follow
    op      = 3'd3;
    in0     = 32'd100;
    in1     = 32'd7;
    start32 = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back('{1'b0, 1'b1, hm[0], lm[0], "rst_busy"});
    sb.push_back('{1'b0, 1'b0, 32'd0, 32'd0, "rst_abort"});
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hm[0] = 32'd0;
    lm[0] = 32'd0;
    for (int i = 0; i < 12; i++) sb.push_back('{1'b0, 1'b0, 32'd0, 32'd0, "no_commit"});
    wait_drain();

    run_op(1'b1, 3'd0, 32'h0000_00FF, 32'h0000_0002, 1, 32'h0000_00FF, 32'h0000_00FE, "w8_mult");
    run_op(1'b1, 3'd2, 32'h0000_00F8, 32'h0000_0003, 2, 32'h0000_00FE, 32'h0000_00FE, "w8_div");
    run_op(1'b1, 3'd2, 32'h0000_0080, 32'h0000_00FF, 2, 32'h0000_0000, 32'h0000_0080, "w8_ovf");
    run_op(1'b1, 3'd1, 32'h0000_00FF, 32'h0000_00FF, 1, 32'h0000_00FE, 32'h0000_0001, "w8_multu");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
